// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM unified-memory port arbiter.
package mem_port_arbiter_pkg;

    localparam bit TRUE  = 1'b1;
    localparam bit FALSE = 1'b0;

    localparam int unsigned MAX_D_STREAK_DEFAULT = 4;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY_IF = 2'd1,
        ARB_BUSY_D  = 2'd2
    } arb_state_t;

    // Counter width able to hold 0..max_streak inclusive.
    function automatic int unsigned streak_w(input int unsigned max_streak);
        return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
    endfunction

endpackage

// File: rtl/mem_arb_policy.sv
// Grant policy: data side wins contention until its streak limit, then one fetch is forced through.
module mem_arb_policy
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_D_STREAK = MAX_D_STREAK_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req_eff,
    input  logic d_req,
    input  logic idle,
    input  logic grant_if,
    output logic pick_d
);

    localparam int unsigned SW = streak_w(MAX_D_STREAK);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    logic [SW-1:0] streak;

    always_comb begin
        pick_d = d_req & (~if_req_eff | (streak < STREAK_MAX));
    end

    // Only grants won against a waiting fetch count towards the streak.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak <= '0;
        end else if (idle) begin
            if (grant_if) begin
                streak <= '0;
            end else if (pick_d & if_req_eff) begin
                streak <= streak + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF fetches and MEM load/stores onto one variable-latency memory port.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MAX_D_STREAK = MAX_D_STREAK_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    input  logic                  if_flush,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_valid,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_wstrb,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_valid,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ready,
    output logic                  if_stall,
    output logic                  d_stall
);

    arb_state_t state;
    logic       kill;
    logic       if_req_eff;
    logic       arb_en;
    logic       pick_d;
    logic       grant_if;
    logic       grant_d;

    // The completion (valid) cycle never arbitrates, so a requester still
    // dropping its request there can neither be re-granted nor jump the queue.
    always_comb begin
        if_req_eff = if_req & ~if_flush;
        arb_en     = (state == ARB_IDLE) & ~if_valid & ~d_valid;
        grant_d    = arb_en & pick_d;
        grant_if   = arb_en & if_req_eff & ~pick_d;
    end

    always_comb begin
        if_stall = if_req & ~if_valid & ~if_flush;
        d_stall  = d_req & ~d_valid;
    end

    mem_arb_policy #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_policy (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req_eff (if_req_eff),
        .d_req      (d_req),
        .idle       (arb_en),
        .grant_if   (grant_if),
        .pick_d     (pick_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            kill      <= FALSE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            if_valid  <= 1'b0;
            d_valid   <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant_d) begin
                        state     <= ARB_BUSY_D;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_wstrb <= d_wstrb;
                    end else if (grant_if) begin
                        state     <= ARB_BUSY_IF;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        mem_wstrb <= '0;
                    end
                end
                ARB_BUSY_IF: begin
                    if (mem_ready) begin
                        state   <= ARB_IDLE;
                        mem_req <= 1'b0;
                        kill    <= FALSE;
                        if (!(kill | if_flush)) begin
                            if_rdata <= mem_rdata;
                            if_valid <= 1'b1;
                        end
                    end else if (if_flush) begin
                        kill <= TRUE;
                    end
                end
                ARB_BUSY_D: begin
                    if (mem_ready) begin
                        state   <= ARB_IDLE;
                        mem_req <= 1'b0;
                        d_valid <= 1'b1;
                        if (!mem_we) begin
                            d_rdata <= mem_rdata;
                        end
                    end
                end
                default: begin
                    state   <= ARB_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
